// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: 2-flop synchroniser, tick-sampled debouncer, press/release pulses.
// Define BUTTON_COND_REPEAT_EN to compile in per-channel auto-repeat on o_repeat.
module button_conditioner #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 17,
  parameter int STABLE_N    = 3,
  parameter int REPEAT_DLY  = 32,
  parameter int REPEAT_RATE = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_tick
);

  localparam int CNT_W = $clog2(STABLE_N + 1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_N);

  if (N_CH < 1 || N_CH > 16 || DIV_W < 1 || DIV_W > 24 || STABLE_N < 1 || STABLE_N > 15 ||
      REPEAT_DLY < 1 || REPEAT_DLY > 255 || REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_param_check
    $error("button_conditioner: parameter out of range");
  end

  // Saturates at STABLE_N so the count can never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == STABLE_C) ? v : v + CNT_W'(1);
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [N_CH-1:0]  sync_p0;
  logic [N_CH-1:0]  sync_p1;
  logic [CNT_W-1:0] cnt     [N_CH];
  logic [CNT_W-1:0] cnt_inc [N_CH];
  logic [N_CH-1:0]  flip;

  assign tick   = &div_cnt;
  assign o_tick = tick;

  always_comb begin
    cnt_inc = '{default: '0};
    flip    = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_inc[i] = sat_inc(cnt[i]);
      flip[i]    = (sync_p1[i] != o_level[i]) && (cnt_inc[i] == STABLE_C);
    end
  end

  // Stage p0/p1: synchroniser; then tick-gated debounce count and level/edge registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt   <= '0;
      sync_p0   <= '0;
      sync_p1   <= '0;
      o_level   <= '0;
      o_press   <= '0;
      o_release <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
      sync_p0   <= i_btn;
      sync_p1   <= sync_p0;
      o_press   <= tick ? (flip & ~o_level) : '0;
      o_release <= tick ? (flip & o_level) : '0;
      if (tick) begin
        o_level <= o_level ^ flip;
        for (int i = 0; i < N_CH; i++)
          cnt[i] <= ((sync_p1[i] == o_level[i]) || flip[i]) ? '0 : cnt_inc[i];
      end
    end
  end

`ifdef BUTTON_COND_REPEAT_EN
  localparam logic [7:0] DLY_C  = 8'(REPEAT_DLY);
  localparam logic [7:0] RATE_C = 8'(REPEAT_RATE);

  // hold counts ticks within the current phase: first up to REPEAT_DLY, then REPEAT_RATE.
  logic [7:0]      hold     [N_CH];
  logic [7:0]      hold_inc [N_CH];
  logic [N_CH-1:0] rep_phase;
  logic [N_CH-1:0] rep_hit;

  always_comb begin
    hold_inc = '{default: '0};
    rep_hit  = '0;
    for (int i = 0; i < N_CH; i++) begin
      hold_inc[i] = hold[i] + 8'd1;
      rep_hit[i]  = o_level[i] && !flip[i] && (hold_inc[i] == (rep_phase[i] ? RATE_C : DLY_C));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_repeat  <= '0;
      rep_phase <= '0;
      for (int i = 0; i < N_CH; i++) hold[i] <= '0;
    end else begin
      o_repeat <= tick ? rep_hit : '0;
      if (tick) begin
        for (int i = 0; i < N_CH; i++) begin
          if (!o_level[i] || flip[i]) begin
            hold[i]      <= '0;
            rep_phase[i] <= 1'b0;
          end else if (rep_hit[i]) begin
            hold[i]      <= '0;
            rep_phase[i] <= 1'b1;
          end else begin
            hold[i]      <= hold_inc[i];
          end
        end
      end
    end
  end
`else
  assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a sample-history reference model predicts pulses and levels.
module tb_button_conditioner;
  localparam int N_CH = 4, DIV_W = 2, STABLE_N = 3, REPEAT_DLY = 4, REPEAT_RATE = 2;
  localparam int TICK_PER = 1 << DIV_W;

  logic i_clk = 1'b0;
  logic i_rst;
  logic [N_CH-1:0] i_btn;
  logic [N_CH-1:0] o_level, o_press, o_release, o_repeat;
  logic o_tick;

  button_conditioner #(
    .N_CH(N_CH), .DIV_W(DIV_W), .STABLE_N(STABLE_N),
    .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn), .o_level(o_level), .o_press(o_press),
    .o_release(o_release), .o_repeat(o_repeat), .o_tick(o_tick)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int cyc;
    logic [N_CH-1:0] pr;
    logic [N_CH-1:0] rl;
    logic [N_CH-1:0] rp;
  } ev_t;

  ev_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state
  int since_rst = 0;
  logic [N_CH-1:0] dq[$] = '{4'h0, 4'h0};
  bit hist [N_CH][$];
  int held [N_CH];
  logic [N_CH-1:0] m_level = '0;
  logic exp_tick = 1'b0;

  // Observations
  int press_cnt [N_CH];
  int rel_cnt [N_CH];
  int rep_cnt [N_CH];
  int last_press_cyc [N_CH];
  int last_rel_cyc [N_CH];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Model: the synchronised sample is the input two edges old; a level flips once the
  // latest STABLE_N tick samples since the previous flip all disagree with it.
  always @(posedge i_clk) begin
    ev_t e;
    logic [N_CH-1:0] s;
    bit tk;
    bit fl;
    cyc++;
    e.cyc = cyc; e.pr = '0; e.rl = '0; e.rp = '0;
    if (i_rst) begin
      since_rst = 0;
      dq = '{4'h0, 4'h0};
      m_level = '0;
      exp_tick = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        hist[c].delete();
        held[c] = 0;
      end
    end else begin
      tk = (since_rst % TICK_PER) == TICK_PER - 1;
      since_rst++;
      s = dq.pop_front();
      dq.push_back(i_btn);
      if (tk) begin
        for (int c = 0; c < N_CH; c++) begin
          hist[c].push_back(s[c]);
          fl = (hist[c].size() >= STABLE_N);
          for (int k = 1; k <= STABLE_N; k++)
            if (fl && hist[c][hist[c].size() - k] == m_level[c]) fl = 0;
`ifdef BUTTON_COND_REPEAT_EN
          if (m_level[c] && !fl) begin
            held[c]++;
            if (held[c] == REPEAT_DLY ||
                (held[c] > REPEAT_DLY && (held[c] - REPEAT_DLY) % REPEAT_RATE == 0))
              e.rp[c] = 1'b1;
          end else held[c] = 0;
`endif
          if (fl) begin
            if (m_level[c]) e.rl[c] = 1'b1; else e.pr[c] = 1'b1;
            m_level[c] = ~m_level[c];
            hist[c].delete();
          end
        end
      end
      exp_tick = (since_rst % TICK_PER) == TICK_PER - 1;
    end
    if ((e.pr | e.rl | e.rp) != '0) sb.push_back(e);
  end

  // Monitor: pops an expected event whenever the DUT emits any pulse.
  always @(negedge i_clk) begin
    ev_t e;
    if (i_rst) begin
      chk("reset_outputs", {15'h0, o_level, o_press, o_release, o_repeat, o_tick}, 32'h0);
      while (sb.size() > 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
    end else begin
      chk("level", 32'(o_level), 32'(m_level));
      chk("tick", 32'(o_tick), 32'(exp_tick));
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        chk("missed_pulse_cyc", 32'(cyc), 32'(e.cyc));
      end
      for (int c = 0; c < N_CH; c++) begin
        if (o_press[c])   begin press_cnt[c]++; last_press_cyc[c] = cyc; end
        if (o_release[c]) begin rel_cnt[c]++;   last_rel_cyc[c]   = cyc; end
        if (o_repeat[c])  rep_cnt[c]++;
      end
      if ((o_press | o_release | o_repeat) != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {20'h0, o_press, o_release, o_repeat}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("pulse_cyc", 32'(cyc), 32'(e.cyc));
          chk("press", 32'(o_press), 32'(e.pr));
          chk("release", 32'(o_release), 32'(e.rl));
          chk("repeat", 32'(o_repeat), 32'(e.rp));
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int p;
    int reps;
    bit found;
    for (int c = 0; c < N_CH; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; rep_cnt[c] = 0;
      last_press_cyc[c] = -1; last_rel_cyc[c] = -1; held[c] = 0;
    end
    i_rst = 1'b1;
    i_btn = 4'b0001;
    cycles(3);
    r = cyc;
    i_rst = 1'b0;
    cycles(20);
    chk("s1_press0_count", 32'(press_cnt[0]), 32'd1);
    chk("s1_press0_latency", 32'(last_press_cyc[0] - r), 32'd12);
    chk("s1_other_press", 32'(press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);

    // Short glitch on channel 1
    i_btn[1] = 1'b1;
    cycles(6);
    i_btn[1] = 1'b0;
    cycles(20);
    chk("s2_press1", 32'(press_cnt[1]), 32'd0);
    chk("s2_release1", 32'(rel_cnt[1]), 32'd0);

    // Simultaneous channels 2 and 3
    i_btn[3:2] = 2'b11;
    cycles(20);
    i_btn[3:2] = 2'b00;
    cycles(20);
    chk("s3_press2", 32'(press_cnt[2]), 32'd1);
    chk("s3_press_same_cyc", 32'(last_press_cyc[3]), 32'(last_press_cyc[2]));
    chk("s3_release_same_cyc", 32'(last_rel_cyc[3]), 32'(last_rel_cyc[2]));

    // Reset after two differing samples on channel 0
    i_btn[0] = 1'b0;
    cycles(20);
    found = 0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge i_clk);
      if (o_tick) found = 1;
    end
    chk("s4_tick_seen", 32'(found), 32'd1);
    @(posedge i_clk); #2;
    i_btn[0] = 1'b1;
    cycles(8);
    i_rst = 1'b1;
    cycles(2);
    r = cyc;
    p = press_cnt[0];
    i_rst = 1'b0;
    for (int k = 0; k < 30 && press_cnt[0] == p; k++) cycles(1);
    chk("s4_press_after_reset", 32'(last_press_cyc[0] - r), 32'd12);

    // Hold for auto-repeat, release timed so the release tick is hold tick 14
    p = last_press_cyc[0];
    reps = rep_cnt[0];
    for (int k = 0; k < 100 && cyc < p + 44; k++) cycles(1);
    i_btn[0] = 1'b0;
    cycles(30);
    chk("s5_release_cyc", 32'(last_rel_cyc[0] - p), 32'd56);
`ifdef BUTTON_COND_REPEAT_EN
    chk("s5_repeat_count", 32'(rep_cnt[0] - reps), 32'd5);
`else
    chk("s5_repeat_count", 32'(rep_cnt[0] - reps), 32'd0);
`endif
    reps = rep_cnt[0];
    cycles(40);
    chk("s5_no_repeat_after_release", 32'(rep_cnt[0]), 32'(reps));

    // Random stimulus
    for (int i = 0; i < 60; i++) begin
      i_btn = 4'($urandom);
      cycles($urandom_range(1, 24));
    end
    i_btn = '0;
    cycles(40);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
